// File: rtl/eq_gain_mixer_pkg.sv
// ----------------------------------------------------------------------------
// eq_pkg
// Shared types and width helpers for the EQ gain mixer slice.
//   eq_mix_state_t : sequencing states of the time-shared MAC
//   GAIN_UNITY     : Q2.14 unity gain, the reset value of every gain entry
//   idx_w()        : index width for a count, never narrower than 1 bit
//   acc_w()        : accumulator width wide enough that summing all bands
//                    can never wrap
//   scaled_w()     : width of accumulator times zero-extended scale
// ----------------------------------------------------------------------------
package eq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_SCALE,
        ST_STORE,
        ST_DONE
    } eq_mix_state_t;

    localparam logic [15:0] GAIN_UNITY = 16'h4000;

    // Index width for n entries; a single entry still gets a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One guard bit per doubling of the band count keeps the sum exact
    function automatic int acc_w(input int din_w, input int gain_w, input int num_bands);
        return din_w + gain_w + $clog2(num_bands);
    endfunction

    // Scale is unsigned, so it is widened by one zero bit before the signed multiply
    function automatic int scaled_w(input int accum_w, input int scale_w);
        return accum_w + scale_w + 1;
    endfunction

endpackage

// File: rtl/eq_gain_mixer_if.sv
// ----------------------------------------------------------------------------
// eq_gain_mixer_if
// Control, gain-programming, sample and result signals of the EQ gain mixer.
//   master modport : the block that feeds samples and programs gains
//   slave modport  : the mixer itself
// Signals:
//   run, bypass, bypass_band              operating mode
//   gain_wr, gain_wr_ch/band/data         gain register write port
//   scale_value, overrun_clr              output scale / flag clear
//   in_stb, data_in                       input sample strobe and bands
//   out_valid, data_out                   result strobe and outputs
//   busy, overrun, sat_flag               status
// ----------------------------------------------------------------------------
interface eq_gain_mixer_if #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_CHANS = 2,
    parameter int DIN_W     = 48,
    parameter int GAIN_W    = 16,
    parameter int SCALE_W   = 13,
    parameter int DOUT_W    = 24
);
    import eq_pkg::*;

    localparam int BW = idx_w(NUM_BANDS);
    localparam int CW = idx_w(NUM_CHANS);

    logic                                 run;
    logic                                 bypass;
    logic [BW-1:0]                        bypass_band;
    logic                                 gain_wr;
    logic [CW-1:0]                        gain_wr_ch;
    logic [BW-1:0]                        gain_wr_band;
    logic [GAIN_W-1:0]                    gain_wr_data;
    logic [SCALE_W-1:0]                   scale_value;
    logic                                 overrun_clr;
    logic                                 in_stb;
    logic [NUM_CHANS*NUM_BANDS*DIN_W-1:0] data_in;
    logic                                 out_valid;
    logic [NUM_CHANS*DOUT_W-1:0]          data_out;
    logic                                 busy;
    logic                                 overrun;
    logic [NUM_CHANS-1:0]                 sat_flag;

    modport master (
        output run, bypass, bypass_band,
        output gain_wr, gain_wr_ch, gain_wr_band, gain_wr_data,
        output scale_value, overrun_clr, in_stb, data_in,
        input  out_valid, data_out, busy, overrun, sat_flag
    );

    modport slave (
        input  run, bypass, bypass_band,
        input  gain_wr, gain_wr_ch, gain_wr_band, gain_wr_data,
        input  scale_value, overrun_clr, in_stb, data_in,
        output out_valid, data_out, busy, overrun, sat_flag
    );

endinterface

// File: rtl/eq_gain_mixer_gain_bank.sv
// ----------------------------------------------------------------------------
// eq_gain_bank
// NUM_CHANS x NUM_BANDS register file of signed Q2.14 gains.
//   clk, reset_n           clock, synchronous active-low reset (all -> unity)
//   wr_en_i                write strobe
//   wr_ch_i, wr_band_i     write address; out-of-range addresses are dropped
//   wr_data_i              write value, visible from the next cycle
//   rd_ch_i, rd_band_i     asynchronous read address
//   rd_data_o              gain at the read address (old value on a same-cycle write)
// ----------------------------------------------------------------------------
module eq_gain_bank
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int NUM_CHANS = 2,
    parameter int GAIN_W    = 16,
    parameter int BW        = 2,
    parameter int CW        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [CW-1:0]     wr_ch_i,
    input  logic [BW-1:0]     wr_band_i,
    input  logic [GAIN_W-1:0] wr_data_i,
    input  logic [CW-1:0]     rd_ch_i,
    input  logic [BW-1:0]     rd_band_i,
    output logic [GAIN_W-1:0] rd_data_o
);

    localparam int ENTRIES = NUM_CHANS * NUM_BANDS;
    localparam int AW      = idx_w(ENTRIES);

    logic [GAIN_W-1:0] gain_q [ENTRIES];
    logic [AW-1:0]     wrIdx_d;
    logic [AW-1:0]     rdIdx_d;
    logic              wrOk_d;

    // Flatten {ch,band} into a linear entry index and screen out addresses
    // that fall outside the populated part of the address space
    always_comb begin
        wrIdx_d = AW'(int'(wr_ch_i) * NUM_BANDS + int'(wr_band_i));
        rdIdx_d = AW'(int'(rd_ch_i) * NUM_BANDS + int'(rd_band_i));
        wrOk_d  = wr_en_i && (int'(wr_ch_i) < NUM_CHANS) && (int'(wr_band_i) < NUM_BANDS);
    end

    // Gain storage: every entry returns to unity on reset, then one write per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                gain_q[i] <= GAIN_W'(GAIN_UNITY);
            end
        end else if (wrOk_d) begin
            gain_q[wrIdx_d] <= wr_data_i;
        end
    end

    assign rd_data_o = gain_q[rdIdx_d];

endmodule

// File: rtl/eq_gain_mixer.sv
// ----------------------------------------------------------------------------
// eq_gain_mixer
// Weighted sum of a filter bank's band outputs per channel, followed by an
// output scale, arithmetic shift and saturation. A single MAC is shared by
// all channels and bands.
//   clk, reset_n   clock, synchronous active-low reset
//   mix_if         eq_gain_mixer_if.slave: mode, gain writes, samples,
//                  results and status (see the interface header)
// Per channel: MAC (NUM_BANDS cycles) -> DRAIN -> SCALE -> STORE, then DONE
// publishes all channel results together with a one-cycle out_valid.
// ----------------------------------------------------------------------------
module eq_gain_mixer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int NUM_CHANS = 2,
    parameter int DIN_W     = 48,
    parameter int GAIN_W    = 16,
    parameter int SCALE_W   = 13,
    parameter int OUT_SHIFT = 26,
    parameter int DOUT_W    = 24
) (
    input  logic           clk,
    input  logic           reset_n,
    eq_gain_mixer_if.slave mix_if
);

    localparam int BW     = idx_w(NUM_BANDS);
    localparam int CW     = idx_w(NUM_CHANS);
    localparam int PROD_W = DIN_W + GAIN_W;
    localparam int ACC_W  = acc_w(DIN_W, GAIN_W, NUM_BANDS);
    localparam int SCL_W  = scaled_w(ACC_W, SCALE_W);

    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);
    localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANS - 1);

    localparam logic signed [SCL_W-1:0]  SAT_MAX = {{(SCL_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [SCL_W-1:0]  SAT_MIN = {{(SCL_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
    localparam logic signed [DOUT_W-1:0] OUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] OUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

    eq_mix_state_t                        state_q;
    logic [BW-1:0]                        band_q;
    logic [CW-1:0]                        chan_q;
    logic [NUM_CHANS*NUM_BANDS*DIN_W-1:0] data_q;
    logic [SCALE_W-1:0]                   scale_q;
    logic                                 bypass_q;
    logic [BW-1:0]                        bypassBand_q;
    logic signed [PROD_W-1:0]             prod_q;
    logic signed [ACC_W-1:0]              acc_q;
    logic signed [SCL_W-1:0]              scaled_q;
    logic [NUM_CHANS*DOUT_W-1:0]          result_q;
    logic [NUM_CHANS*DOUT_W-1:0]          dataOut_q;
    logic                                 outValid_q;
    logic                                 overrun_q;
    logic [NUM_CHANS-1:0]                 sat_q;

    logic [GAIN_W-1:0]                    gainRd;
    logic signed [DIN_W-1:0]              sample_d;
    logic signed [GAIN_W-1:0]             effGain_d;
    logic signed [PROD_W-1:0]             prod_d;
    logic signed [SCL_W-1:0]              scaled_d;
    logic signed [SCL_W-1:0]              shifted_d;
    logic signed [DOUT_W-1:0]             satOut_d;
    logic                                 satHit_d;

    eq_gain_bank #(
        .NUM_BANDS (NUM_BANDS),
        .NUM_CHANS (NUM_CHANS),
        .GAIN_W    (GAIN_W),
        .BW        (BW),
        .CW        (CW)
    ) u_gain_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (mix_if.gain_wr),
        .wr_ch_i   (mix_if.gain_wr_ch),
        .wr_band_i (mix_if.gain_wr_band),
        .wr_data_i (mix_if.gain_wr_data),
        .rd_ch_i   (chan_q),
        .rd_band_i (band_q),
        .rd_data_o (gainRd)
    );

    // Datapath: pick the current band sample and its gain (bypass forces unity
    // on one band and silences the rest), form the product, the scaled sum,
    // and the shifted/saturated channel result
    always_comb begin
        sample_d = data_q[(int'(chan_q) * NUM_BANDS + int'(band_q)) * DIN_W +: DIN_W];
        if (bypass_q) begin
            effGain_d = (band_q == bypassBand_q) ? GAIN_W'(GAIN_UNITY) : '0;
        end else begin
            effGain_d = gainRd;
        end
        prod_d    = PROD_W'(sample_d) * PROD_W'(effGain_d);
        scaled_d  = SCL_W'(acc_q) * SCL_W'($signed({1'b0, scale_q}));
        shifted_d = scaled_q >>> OUT_SHIFT;
        satHit_d  = 1'b0;
        satOut_d  = shifted_d[DOUT_W-1:0];
        if (shifted_d > SAT_MAX) begin
            satOut_d = OUT_MAX;
            satHit_d = 1'b1;
        end else if (shifted_d < SAT_MIN) begin
            satOut_d = OUT_MIN;
            satHit_d = 1'b1;
        end
    end

    // Sequencer and registered outputs. The product is registered one cycle
    // ahead of the accumulate, so band 0 clears the accumulator while its own
    // product is formed and DRAIN folds in the final band. Channel results
    // collect in result_q and are published together in DONE, which keeps
    // data_out intact across an abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            band_q       <= '0;
            chan_q       <= '0;
            data_q       <= '0;
            scale_q      <= '0;
            bypass_q     <= 1'b0;
            bypassBand_q <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            scaled_q     <= '0;
            result_q     <= '0;
            dataOut_q    <= '0;
            outValid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            sat_q        <= '0;
        end else begin
            outValid_q <= 1'b0;

            if (mix_if.in_stb && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (mix_if.overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (mix_if.overrun_clr) begin
                sat_q <= '0;
            end

            if (!mix_if.run) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (mix_if.in_stb) begin
                            data_q       <= mix_if.data_in;
                            scale_q      <= mix_if.scale_value;
                            bypass_q     <= mix_if.bypass;
                            bypassBand_q <= mix_if.bypass_band;
                            band_q       <= '0;
                            chan_q       <= '0;
                            state_q      <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        prod_q <= prod_d;
                        if (band_q == '0) begin
                            acc_q <= '0;
                        end else begin
                            acc_q <= acc_q + ACC_W'(prod_q);
                        end
                        if (band_q == LAST_BAND) begin
                            band_q  <= '0;
                            state_q <= ST_DRAIN;
                        end else begin
                            band_q <= band_q + BW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        acc_q   <= acc_q + ACC_W'(prod_q);
                        state_q <= ST_SCALE;
                    end
                    ST_SCALE: begin
                        scaled_q <= scaled_d;
                        state_q  <= ST_STORE;
                    end
                    ST_STORE: begin
                        result_q[int'(chan_q) * DOUT_W +: DOUT_W] <= satOut_d;
                        if (satHit_d) begin
                            sat_q[chan_q] <= 1'b1;
                        end
                        if (chan_q == LAST_CHAN) begin
                            state_q <= ST_DONE;
                        end else begin
                            chan_q  <= chan_q + CW'(1);
                            state_q <= ST_MAC;
                        end
                    end
                    ST_DONE: begin
                        dataOut_q  <= result_q;
                        outValid_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mix_if.out_valid = outValid_q;
    assign mix_if.data_out  = dataOut_q;
    assign mix_if.busy      = (state_q != ST_IDLE);
    assign mix_if.overrun   = overrun_q;
    assign mix_if.sat_flag  = sat_q;

endmodule
